// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, Hack comp encodings,
// the pipeline operand record and a one-hot to index helper.
package alu_pkg;

   localparam int ALU_W  = 16;
   localparam int CTRL_W = 6;
   localparam int ID_W   = 2;
   localparam int MAXREQ = 4;

   // Hack comp encodings, bit order {zx,nx,zy,ny,f,no}
   localparam logic [CTRL_W-1:0] C_ZERO      = 6'b101010;
   localparam logic [CTRL_W-1:0] C_ONE       = 6'b111111;
   localparam logic [CTRL_W-1:0] C_X_PLUS_Y  = 6'b000010;
   localparam logic [CTRL_W-1:0] C_X_AND_Y   = 6'b000000;
   localparam logic [CTRL_W-1:0] C_X_MINUS_Y = 6'b010011;

   // Operand record held in the first pipeline stage
   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ALU_W-1:0]  x;
      logic [ALU_W-1:0]  y;
      logic [CTRL_W-1:0] ctrl;
   } op_t;

   // Index of the set bit of a one-hot vector (0 when the vector is empty)
   function automatic logic [ID_W-1:0] oh_to_idx(input logic [MAXREQ-1:0] oh);
      logic [ID_W-1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < MAXREQ; i++) begin
         idx = idx | (oh[i] ? 2'(i) : 2'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ALU.sv
// Hack ALU: purely combinational 16-bit compute unit with zr/ng flags.
module ALU
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] x_i,
   input  logic [ALU_W-1:0] y_i,
   input  logic             zx_i,
   input  logic             nx_i,
   input  logic             zy_i,
   input  logic             ny_i,
   input  logic             f_i,
   input  logic             no_i,
   output logic [ALU_W-1:0] out_o,
   output logic             zr_o,
   output logic             ng_o
);

   logic [ALU_W-1:0] xa_s;
   logic [ALU_W-1:0] ya_s;
   logic [ALU_W-1:0] fo_s;

   // Zero/negate each operand, apply add or and, optionally negate the result
   always_comb begin
      xa_s  = zx_i ? 16'h0000 : x_i;
      xa_s  = nx_i ? ~xa_s : xa_s;
      ya_s  = zy_i ? 16'h0000 : y_i;
      ya_s  = ny_i ? ~ya_s : ya_s;
      fo_s  = f_i ? (xa_s + ya_s) : (xa_s & ya_s);
      out_o = no_i ? ~fo_s : fo_s;
      zr_o  = (out_o == 16'h0000);
      ng_o  = out_o[ALU_W-1];
   end

endmodule

// File: rtl/alu_rr_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module alu_rr_pick #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [1:0]      ptr_i,
   output logic [NREQ-1:0] grant_o
);

   int   idx_s;
   logic found_s;

   // Walk the requesters starting at ptr and grant the first active one
   always_comb begin
      grant_o = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = int'(ptr_i) + k;
         if (idx_s >= NREQ) begin
            idx_s = idx_s - NREQ;
         end else begin
            idx_s = idx_s;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!found_s && (i == idx_s) && req_i[i]) begin
               grant_o[i] = 1'b1;
               found_s    = 1'b1;
            end else begin
               grant_o[i] = grant_o[i];
            end
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Hack ALU between NREQ requesters: round-robin arbitration with
// bounded lock bursts, operand register -> ALU -> result register pipeline.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int MAX_LOCK = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_lock,
   input  logic [16*NREQ-1:0]    req_x,
   input  logic [16*NREQ-1:0]    req_y,
   input  logic [6*NREQ-1:0]     req_ctrl,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_id,
   output logic [15:0]           rsp_out,
   output logic                  rsp_zr,
   output logic                  rsp_ng
);

   // Pipeline state
   logic             s1_valid_q;
   op_t              s1_q;
   logic             rsp_valid_q;
   logic [1:0]       rsp_id_q;
   logic [ALU_W-1:0] rsp_out_q;
   logic             rsp_zr_q;
   logic             rsp_ng_q;

   // Arbitration state
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic             lock_vld_q, lock_vld_d;
   logic [1:0]       lock_owner_q, lock_owner_d;
   logic [3:0]       lock_cnt_q, lock_cnt_d;

   // Combinational helpers
   logic             advance1_s, advance2_s;
   logic             owner_valid_s, lock_active_s;
   logic [NREQ-1:0]  owner_oh_s, grant_rr_s, grant_s;
   logic             accept_s, sel_lock_s;
   logic [1:0]       grant_idx_s;
   logic [3:0]       base_cnt_s;
   op_t              sel_op_s;
   logic [ALU_W-1:0] alu_out_s;
   logic             alu_zr_s, alu_ng_s;

   // A stage may take new data when it is empty or its content moves on
   assign advance2_s = !rsp_valid_q || rsp_ready;
   assign advance1_s = !s1_valid_q || advance2_s;

   // Decode the lock owner and whether it is still requesting
   always_comb begin
      owner_oh_s    = '0;
      owner_valid_s = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (lock_owner_q == 2'(i)) begin
            owner_oh_s[i] = 1'b1;
            owner_valid_s = req_valid[i];
         end else begin
            owner_oh_s[i] = 1'b0;
         end
      end
   end

   assign lock_active_s = lock_vld_q && owner_valid_s;

   alu_rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant_rr_s)
   );

   // A live lock overrides round-robin; ready is withheld during reset
   assign grant_s     = lock_active_s ? owner_oh_s : grant_rr_s;
   assign req_ready   = grant_s & {NREQ{advance1_s & rst_n}};
   assign accept_s    = |(req_valid & req_ready);
   assign grant_idx_s = oh_to_idx(4'(grant_s));
   assign sel_lock_s  = |(req_lock & grant_s);
   assign base_cnt_s  = lock_active_s ? lock_cnt_q : 4'd0;

   // Select the granted requester's operands
   always_comb begin
      sel_op_s    = '0;
      sel_op_s.id = grant_idx_s;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_s[i]) begin
            sel_op_s.x    = req_x[16*i +: 16];
            sel_op_s.y    = req_y[16*i +: 16];
            sel_op_s.ctrl = req_ctrl[6*i +: 6];
         end else begin
            sel_op_s = sel_op_s;
         end
      end
   end

   // Next round-robin pointer and lock burst state
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_vld_d   = lock_vld_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;
      if (accept_s) begin
         rr_ptr_d = (grant_idx_s == 2'(NREQ-1)) ? 2'd0 : (grant_idx_s + 2'd1);
         if (sel_lock_s && ((base_cnt_s + 4'd1) < 4'(MAX_LOCK))) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = grant_idx_s;
            lock_cnt_d   = base_cnt_s + 4'd1;
         end else begin
            lock_vld_d = 1'b0;
            lock_cnt_d = 4'd0;
         end
      end else if (lock_vld_q && !owner_valid_s) begin
         lock_vld_d = 1'b0;
         lock_cnt_d = 4'd0;
      end else begin
         lock_vld_d = lock_vld_q;
      end
   end

   // Arbitration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= 2'd0;
         lock_vld_q   <= 1'b0;
         lock_owner_q <= 2'd0;
         lock_cnt_q   <= 4'd0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_vld_q   <= lock_vld_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   // Operand stage: capture the accepted op whenever the stage can move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else if (advance1_s) begin
         s1_valid_q <= accept_s;
         if (accept_s) begin
            s1_q <= sel_op_s;
         end else begin
            s1_q <= s1_q;
         end
      end else begin
         s1_valid_q <= s1_valid_q;
      end
   end

   ALU u_alu (
      .x_i   (s1_q.x),
      .y_i   (s1_q.y),
      .zx_i  (s1_q.ctrl[5]),
      .nx_i  (s1_q.ctrl[4]),
      .zy_i  (s1_q.ctrl[3]),
      .ny_i  (s1_q.ctrl[2]),
      .f_i   (s1_q.ctrl[1]),
      .no_i  (s1_q.ctrl[0]),
      .out_o (alu_out_s),
      .zr_o  (alu_zr_s),
      .ng_o  (alu_ng_s)
   );

   // Result stage: hold while downstream stalls, else take the ALU result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 2'd0;
         rsp_out_q   <= 16'h0000;
         rsp_zr_q    <= 1'b0;
         rsp_ng_q    <= 1'b0;
      end else if (advance2_s) begin
         rsp_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            rsp_id_q  <= s1_q.id;
            rsp_out_q <= alu_out_s;
            rsp_zr_q  <= alu_zr_s;
            rsp_ng_q  <= alu_ng_s;
         end else begin
            rsp_id_q  <= rsp_id_q;
         end
      end else begin
         rsp_valid_q <= rsp_valid_q;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_out   = rsp_out_q;
   assign rsp_zr    = rsp_zr_q;
   assign rsp_ng    = rsp_ng_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, arbitration and
// lock sequences, backpressure, mid-stream reset and a randomized run against
// a transaction-level model.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ     = 2;
   localparam int MAX_LOCK = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid, req_lock, req_ready;
   logic [16*NREQ-1:0] req_x, req_y;
   logic [6*NREQ-1:0] req_ctrl;
   logic              rsp_valid, rsp_ready, rsp_zr, rsp_ng;
   logic [1:0]        rsp_id;
   logic [15:0]       rsp_out;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_lock(req_lock),
      .req_x(req_x), .req_y(req_y), .req_ctrl(req_ctrl),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng)
   );

   typedef struct {
      logic [1:0]  id;
      logic [15:0] out;
      logic        zr;
      logic        ng;
      bit          at_out;
   } pend_t;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [5:0]  ctrl;
      logic [15:0] out;
      logic        zr;
      logic        ng;
   } vec_t;

   pend_t      pipe[$];
   int         m_rr, m_own, m_cnt;
   bit         m_lk;
   int         n_tests, n_fail, n_acc, n_rsp;
   logic [1:0] last_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hack ALU in plain unsigned arithmetic: returns {zr, ng, out}
   function automatic logic [17:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      int unsigned a, b, r;
      a = c[5] ? 0 : 32'(x);
      if (c[4]) a = 65535 - a;
      b = c[3] ? 0 : 32'(y);
      if (c[2]) b = 65535 - b;
      r = c[1] ? ((a + b) % 65536) : (a & b);
      if (c[0]) r = 65535 - r;
      return {(r == 0), (r >= 32768), 16'(r)};
   endfunction

   task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c);
      req_x[16*i +: 16]  = x;
      req_y[16*i +: 16]  = y;
      req_ctrl[6*i +: 6] = c;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         set_op(i, 16'($urandom), 16'($urandom), 6'($urandom));
      end
   endtask

   // One clock cycle: predict and check outputs, then advance the model
   task automatic cycle();
      bit          out_v, s1f, adv1, adv2, lock_act;
      int          g, idx, rv, lv, base;
      logic [1:0]  exp_ready;
      logic [17:0] r;
      pend_t       e;
      @(negedge clk);
      rv       = int'(req_valid);
      lv       = int'(req_lock);
      out_v    = (pipe.size() > 0) && pipe[0].at_out;
      s1f      = (pipe.size() > 0) && !pipe[pipe.size()-1].at_out;
      adv2     = !out_v || (rsp_ready == 1'b1);
      adv1     = !s1f || adv2;
      lock_act = m_lk && (((rv >> m_own) & 1) != 0);
      g = -1;
      if (lock_act) g = m_own;
      else begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (g < 0 && ((rv >> idx) & 1) != 0) g = idx;
         end
      end
      exp_ready = (g >= 0 && adv1) ? 2'(1 << g) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(out_v));
      if (out_v) begin
         chk("rsp_id",  32'(rsp_id),  32'(pipe[0].id));
         chk("rsp_out", 32'(rsp_out), 32'(pipe[0].out));
         chk("rsp_zr",  32'(rsp_zr),  32'(pipe[0].zr));
         chk("rsp_ng",  32'(rsp_ng),  32'(pipe[0].ng));
      end
      last_ready = req_ready;
      if (out_v && rsp_ready) begin
         void'(pipe.pop_front());
         n_rsp++;
      end
      if (adv2 && pipe.size() > 0 && !pipe[pipe.size()-1].at_out) begin
         e = pipe[pipe.size()-1];
         e.at_out = 1'b1;
         pipe[pipe.size()-1] = e;
      end
      if (exp_ready != 2'b00) begin
         r = ref_alu(16'(req_x >> (16*g)), 16'(req_y >> (16*g)), 6'(req_ctrl >> (6*g)));
         e.id = 2'(g); e.out = r[15:0]; e.zr = r[17]; e.ng = r[16]; e.at_out = 1'b0;
         pipe.push_back(e);
         n_acc++;
         m_rr = (g + 1) % NREQ;
         base = lock_act ? m_cnt : 0;
         if (((lv >> g) & 1) != 0 && (base + 1) < MAX_LOCK) begin
            m_lk = 1'b1; m_own = g; m_cnt = base + 1;
         end else begin
            m_lk = 1'b0; m_cnt = 0;
         end
      end else if (m_lk && !lock_act) begin
         m_lk = 1'b0; m_cnt = 0;
      end
      @(posedge clk); #1;
   endtask

   // Assert reset mid-cycle, check the reset state, release with no requests
   task automatic do_reset();
      @(posedge clk); #2;
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_rsp_out",   32'(rsp_out),   32'd0);
      chk("rst_rsp_zr",    32'(rsp_zr),    32'd0);
      chk("rst_rsp_ng",    32'(rsp_ng),    32'd0);
      pipe.delete();
      m_rr = 0; m_own = 0; m_cnt = 0; m_lk = 1'b0;
      req_valid = 2'b00;
      req_lock  = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t       tbl[7];
   logic [1:0] pat_a[10];
   logic [1:0] pat_b[4];
   logic [1:0] pat_c[4];
   int         acc0, rsp0;

   initial begin
      rst_n = 1'b1; req_valid = '0; req_lock = '0; req_x = '0; req_y = '0;
      req_ctrl = '0; rsp_ready = 1'b1;
      n_tests = 0; n_fail = 0; n_acc = 0; n_rsp = 0;
      m_rr = 0; m_own = 0; m_cnt = 0; m_lk = 1'b0;

      tbl[0] = '{16'd5,    16'd3,    C_X_PLUS_Y,  16'd8,    1'b0, 1'b0};
      tbl[1] = '{16'd3,    16'd5,    C_X_MINUS_Y, 16'hFFFE, 1'b0, 1'b1};
      tbl[2] = '{16'h1234, 16'h5678, C_ZERO,      16'h0000, 1'b1, 1'b0};
      tbl[3] = '{16'h1234, 16'h5678, C_ONE,       16'h0001, 1'b0, 1'b0};
      tbl[4] = '{16'hF0F0, 16'h3C3C, C_X_AND_Y,   16'h3030, 1'b0, 1'b0};
      tbl[5] = '{16'h8000, 16'h8000, C_X_PLUS_Y,  16'h0000, 1'b1, 1'b0};
      tbl[6] = '{16'h7FFF, 16'h0001, C_X_PLUS_Y,  16'h8000, 1'b0, 1'b1};
      pat_a = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      pat_b = '{2'b01, 2'b01, 2'b10, 2'b01};
      pat_c = '{2'b01, 2'b01, 2'b00, 2'b01};

      do_reset();

      // Single ops from requester 0: result visible two edges after accept
      for (int i = 0; i < 7; i++) begin
         set_op(0, tbl[i].x, tbl[i].y, tbl[i].ctrl);
         req_valid = 2'b01;
         cycle();
         req_valid = 2'b00;
         cycle();
         chk("vec_valid", 32'(rsp_valid), 32'd1);
         chk("vec_id",    32'(rsp_id),    32'd0);
         chk("vec_out",   32'(rsp_out),   32'(tbl[i].out));
         chk("vec_zr",    32'(rsp_zr),    32'(tbl[i].zr));
         chk("vec_ng",    32'(rsp_ng),    32'(tbl[i].ng));
         cycle();
      end

      // Contention without lock alternates grants
      do_reset();
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         rand_ops();
         cycle();
         chk("rr_alt", 32'(last_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      end

      // Held lock: MAX_LOCK grants then forced rotation
      do_reset();
      req_valid = 2'b11; req_lock = 2'b01;
      for (int k = 0; k < 10; k++) begin
         rand_ops();
         cycle();
         chk("lock_burst", 32'(last_ready), 32'(pat_a[k]));
      end

      // Owner drops valid while locked: other requester granted at once
      do_reset();
      req_lock = 2'b01;
      for (int k = 0; k < 4; k++) begin
         req_valid = (k == 2) ? 2'b10 : 2'b11;
         rand_ops();
         cycle();
         chk("lock_drop", 32'(last_ready), 32'(pat_b[k]));
      end

      // Backpressure: 3 stalled cycles, nothing lost or duplicated
      do_reset();
      acc0 = n_acc; rsp0 = n_rsp;
      req_valid = 2'b01;
      for (int k = 0; k < 4; k++) begin
         rsp_ready = (k < 3) ? 1'b0 : 1'b1;
         rand_ops();
         cycle();
         chk("bp_ready", 32'(last_ready), 32'(pat_c[k]));
      end
      req_valid = 2'b00;
      repeat (4) cycle();
      chk("bp_accepts", 32'(n_acc - acc0), 32'd3);
      chk("bp_balance", 32'(n_rsp - rsp0), 32'(n_acc - acc0));

      // Reset with both stages full: no stale response afterwards
      rsp_ready = 1'b0;
      req_valid = 2'b01;
      repeat (3) begin rand_ops(); cycle(); end
      do_reset();
      rsp_ready = 1'b1;
      repeat (3) cycle();
      chk("no_stale", 32'(rsp_valid), 32'd0);

      // Randomized traffic against the model
      acc0 = n_acc; rsp0 = n_rsp;
      for (int k = 0; k < 3000; k++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_lock  = 2'($urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         cycle();
      end
      req_valid = 2'b00; rsp_ready = 1'b1;
      repeat (4) cycle();
      chk("rand_balance", 32'(n_rsp - rsp0), 32'(n_acc - acc0));
      chk("rand_drained", 32'(pipe.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
